// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial multiply / restoring divide that owns HI/LO.
// One result bit per cycle; WIDTH RUN cycles followed by one FIX cycle that
// applies sign correction and writes HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               neg_res;   // operand signs differ (signed ops only)
  logic               neg_rem;   // dividend negative (signed div only)
  logic               dz;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // mult: {partial, multiplier}; div: low half dividend -> quotient
  logic [WIDTH-1:0]   rem;       // settled remainder always < divisor, fits WIDTH bits

  logic               sgn_op;
  logic [WIDTH-1:0]   amag_in, bmag_in;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rshift, rdiff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  assign busy      = (state != IDLE);
  assign div_zero  = dz;
  assign state_out = state;

  // Operand magnitudes and one step of each serial algorithm
  always_comb begin
    sgn_op  = ~op[0];
    amag_in = (sgn_op && a[WIDTH-1]) ? -a : a;
    bmag_in = (sgn_op && b[WIDTH-1]) ? -b : b;
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    rshift  = {rem, acc[WIDTH-1]};
    rdiff   = rshift - {1'b0, opnd};
    prod    = (op_r == 2'b00 && neg_res) ? -acc : acc;
    quo     = (op_r == 2'b10 && neg_res) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd     = (op_r == 2'b10 && neg_rem) ? -rem : rem;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: divide by zero skips RUN entirely
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (op[1] && b == '0) ? FIX : RUN;
      RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0; op_r <= '0; neg_res <= 1'b0; neg_rem <= 1'b0; dz <= 1'b0;
      opnd <= '0; acc <= '0; rem <= '0; hi <= '0; lo <= '0; done <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (hi_write) hi <= wdata;
          if (lo_write) lo <= wdata;
          if (start) begin
            op_r    <= op;
            neg_res <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= sgn_op & a[WIDTH-1];
            dz      <= op[1] && (b == '0);
            cnt     <= '0;
            rem     <= '0;
            opnd    <= op[1] ? bmag_in : amag_in;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? amag_in : bmag_in)};
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!op_r[1]) begin
            acc <= {msum, acc[WIDTH-1:1]};
          end else begin
            rem            <= rdiff[WIDTH] ? rshift[WIDTH-1:0] : rdiff[WIDTH-1:0];
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~rdiff[WIDTH]};
          end
        end
        FIX: begin
          if (!dz) begin
            if (!op_r[1]) {hi, lo} <= prod;
            else begin
              lo <= quo;
              hi <= rmd;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; inputs driven and outputs sampled on negedge.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, hi_write, lo_write;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_out;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  bit saw_done;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .state_out(state_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the sampling edge E0
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0;
  endtask

  // lat = number of edges after E0 until done is seen (bounded)
  task automatic wait_done(output int l);
    l = 0;
    while (!done && l < 200) begin
      @(negedge clock);
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; hi_write = 0; lo_write = 0; op = 0; a = 0; b = 0; wdata = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_state", state_out, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // multu max*max, with latency and busy/state checks
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy", busy, 1);
    chk("multu_state", state_out, 1);
    wait_done(lat);
    chk("multu_lat", lat, 33);
    chk("multu_busy_done", busy, 0);
    chk("multu_state_done", state_out, 0);
    chk("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(negedge clock);
    chk("multu_done_1cyc", done, 0);

    // signed mult -3 * 5
    start_op(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(lat);
    chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge clock);

    // signed div -7 / 2
    start_op(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat);
    chk("div_lat", lat, 33);
    chk("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge clock);

    // divu by zero: one busy cycle, HI/LO untouched
    start_op(2'b11, 32'd100, 32'd0);
    chk("dz_busy", busy, 1);
    chk("dz_state", state_out, 2);
    wait_done(lat);
    chk("dz_lat", lat, 1);
    chk("dz_flag", div_zero, 1);
    chk("dz_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge clock);

    // divu 100 / 7, div_zero clears at start
    start_op(2'b11, 32'd100, 32'd7);
    chk("dz_clear", div_zero, 0);
    wait_done(lat);
    chk("divu_res", {hi, lo}, {32'd2, 32'd14});
    @(negedge clock);

    // most-negative / -1
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    @(negedge clock);

    // mult 6*7 with start + mthi ignored mid-run
    start_op(2'b00, 32'd6, 32'd7);
    repeat (9) @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5; hi_write = 1'b1; wdata = 32'hDEAD;
    @(negedge clock);
    start = 1'b0; hi_write = 1'b0;
    chk("ign_hi_stable", hi, 32'h0);
    chk("ign_lo_stable", lo, 32'h80000000);
    chk("ign_busy", busy, 1);
    wait_done(lat);
    chk("ign_res", {hi, lo}, {32'd0, 32'd42});

    // back-to-back start in the done cycle
    start_op(2'b01, 32'd3, 32'd4);
    chk("b2b_done_fell", done, 0);
    chk("b2b_busy", busy, 1);
    wait_done(lat);
    chk("b2b_lat", lat, 33);
    chk("b2b_res", {hi, lo}, {32'd0, 32'd12});
    @(negedge clock);

    // reset mid-operation aborts with no done
    start_op(2'b01, 32'd2, 32'd3);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    chk("abort_state", state_out, 0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);

    // mthi / mtlo while idle
    hi_write = 1'b1; wdata = 32'h1234;
    @(negedge clock);
    hi_write = 1'b0;
    chk("mthi", {hi, lo}, {32'h1234, 32'h0});
    lo_write = 1'b1; wdata = 32'h5678;
    @(negedge clock);
    lo_write = 1'b0;
    chk("mtlo", {hi, lo}, {32'h1234, 32'h5678});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair of the multicycle MIPS core. The control unit issues a one-cycle `start` with an operation code and the A/B register operands. The block then runs a bit-serial shift-add multiply or a restoring divide, one bit per cycle. It writes HI/LO, pulses `done`, and holds `busy` meanwhile so the control unit can stall `mfhi`/`mflo` and further mult/div instructions.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_write  in  1  mthi strobe
- lo_write  in  1  mtlo strobe
- wdata  in  WIDTH  data for mthi/mtlo
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, HI/LO valid
- div_zero  out  1  last accepted divide had b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- state_out  out  2  debug state: IDLE=0, RUN=1, FIX=2

## Operation
- States: IDLE, RUN, FIX. Bit counter of clog2(WIDTH)+1 bits.
- IDLE + start: latch op, sign flags, and magnitudes of a and b. Signed ops take the two's-complement absolute value; unsigned ops pass operands through. Set busy. Clear div_zero. Go to RUN.
- Divide by zero: if op[1]=1 and b == 0 at start, go to FIX directly with div_zero=1. HI/LO are not changed.
- RUN, multiply: 2*WIDTH-bit accumulator. Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half, then shift right one (carry kept).
- RUN, divide: restoring algorithm with a WIDTH+1-bit partial remainder. Each cycle, shift in the next dividend MSB, trial-subtract the divisor, keep the result if non-negative, and shift the quotient bit in.
- RUN lasts exactly WIDTH cycles, then go to FIX.
- FIX, multiply: write {hi,lo} = product. For mult, negate the 2*WIDTH-bit product when the operand signs differ.
- FIX, divide: lo = quotient, hi = remainder.
  - For div, negate the quotient when the signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
- FIX always goes to IDLE on the next edge. That same edge sets done=1 and clears busy.
- start while busy is ignored; there is no queueing.
- hi_write/lo_write update hi/lo from wdata on any edge where busy=0; they are ignored while busy.
- If a write coincides with an accepted start, the write is applied; the operation result overwrites it later.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_zero 0, hi 0, lo 0, counter 0.
- Reset mid-operation aborts immediately: HI/LO=0 and no done pulse.
- Let E0 be the edge that samples start. busy=1 from E0.
- RUN occupies edges E1..E_WIDTH. The FIX edge E_{WIDTH+1} writes HI/LO, sets done=1, and sets busy=0. Latency is WIDTH+1 cycles (33 at default).
- Divide-by-zero: the FIX edge is E1, so done is high after E1 and busy is high for one cycle only.
- done is high for exactly one cycle, during which state is IDLE. A start in that cycle is accepted: done falls and busy rises at the next edge.
- hi/lo change only on the FIX edge, mthi/mtlo edges, or reset. They are stable and readable throughout RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then multu a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done high one cycle after E33.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100 b=0 -> done after E1, div_zero=1, hi/lo unchanged. Then divu a=100 b=7 -> div_zero clears at start; lo=14, hi=2.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start mult 6*7. Pulse start with different operands and hi_write at cycle 10 -> both ignored; result hi=0, lo=42. Start again in the done cycle -> accepted with no idle gap.
- Start multu, assert reset at cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse. Then mthi 0x1234 while idle -> hi=0x1234 next edge.
